weight_load_ctrl: RTL
=====================

Name: weight_load_ctrl

Overview:
- Sequences the loading of convolution kernel weights into the feature weight memory.
- Accepts a serial stream of 2-bit signed weights over a valid/ready handshake and assembles them into one flattened KERNEL_SIZE*KERNEL_SIZE kernel per feature.
- Issues one active-low write per feature at consecutive addresses 0..NUM_FEATURES-1.
- Sits between the off-chip/testbench weight source and the weight memory. It flags completion so the PE array may start.

Parameters:
- KERNEL_SIZE, 3: kernel edge length; K2 = KERNEL_SIZE*KERNEL_SIZE weights per feature.
- NUM_FEATURES, 10: number of feature kernels to load per run.

Ports:
- clk, input, 1: clock; all state updates on posedge.
- rst, input, 1: reset, asynchronous, active-low.
- start, input, 1: begin a load run; sampled only in IDLE.
- abort, input, 1: cancel the current run; synchronous, takes priority over all other inputs except rst.
- w_valid, input, 1: w_data is valid.
- w_data, input, signed 2: next weight, row-major order.
- w_ready, output, 1: controller accepts w_data this cycle.
- address_w, output, $clog2(NUM_FEATURES)+1: feature write address.
- feature_WrEn, output, 1: active-low write enable to the weight memory.
- weights_input, output, signed 2 x K2 (unpacked array): assembled kernel.
- busy, output, 1: high while state is not IDLE.
- done, output, 1: one-cycle pulse when all features are written.
- loaded, output, 1: level; all NUM_FEATURES kernels are valid in memory.

Behaviour:
- Reset (rst=0, async): state=IDLE, feature_WrEn=1, w_ready=0, busy=0, done=0, loaded=0, address_w=0, weights_input all 0, counters cleared.
- States: IDLE, COLLECT, WRITE, DONE. state, counters and kernel buffer are flops.
- feature_WrEn, w_ready, busy and done decode from the state register only, so they are stable across the memory's negedge write.
- IDLE: w_ready=0.
  - start=1 -> COLLECT; clear elem_cnt and feat_cnt; clear loaded.
- COLLECT: w_ready=1.
  - A handshake (w_valid & w_ready) stores w_data into buf[elem_cnt] and increments elem_cnt.
  - A handshake with elem_cnt==K2-1 -> WRITE; elem_cnt wraps to 0.
  - No handshake: hold state and all counters.
- WRITE: exactly one cycle.
  - feature_WrEn=0, w_ready=0, address_w=feat_cnt, weights_input=buf.
  - If feat_cnt==NUM_FEATURES-1 -> DONE; else feat_cnt+1 -> COLLECT.
- DONE: done=1 for one cycle; loaded set to 1 -> IDLE.
- Output stability: address_w and weights_input are driven from registers and hold their values outside WRITE. They never change during a WRITE cycle.
- Latency: minimum NUM_FEATURES*(K2+1) cycles from the start-sampling edge to the last WRITE. done is high in the following cycle (101 for the defaults).
- Boundaries:
  - start while busy: ignored.
  - abort in any non-IDLE state -> IDLE next cycle; no further writes; loaded=0. A write in progress (WRITE state) still completes that cycle, because the state is already registered.
  - abort in IDLE: clears loaded.
  - Async reset mid-run: feature_WrEn rises immediately; the run is lost and requires a new start.
  - Counters never exceed K2-1 or NUM_FEATURES-1. address_w is always < NUM_FEATURES.
  - K2=1: every handshake goes directly to WRITE.

Decomposition:
- Shared package cnn_pkg:
  - weight_t (logic signed [1:0]).
  - wl_state_t enum {IDLE, COLLECT, WRITE, DONE}.
  - Default KERNEL_SIZE and NUM_FEATURES constants.
- No sub-module required. The kernel buffer and elem_cnt may optionally be split out as kernel_assembler, which takes the handshake and emits a full-kernel strobe plus the buffer.

Test Plan:
- Reset: hold rst=0 mid-COLLECT -> immediately feature_WrEn=1, w_ready=0, busy=0, loaded=0, address_w=0, weights_input all 0.
- Full load, defaults, w_valid held 1, weight i = (i mod 3)-1:
  - Expect 10 single-cycle WrEn-low pulses at cycles 10,20,..,100 with address_w 0..9.
  - Feature 0 kernel = {-1,0,1,-1,0,1,-1,0,1}.
  - done pulses at cycle 101; loaded=1 afterwards.
- Random w_valid bubbles (about 50%): every weight is captured exactly once in order. WrEn goes low only after the 9th handshake of each feature.
- start pulsed during COLLECT of feature 3: ignored, sequence unchanged.
- abort after 4 weights of feature 5: IDLE next cycle, no write to address 5, loaded=0. A restart rewrites from address 0.
- Parameter corner KERNEL_SIZE=1, NUM_FEATURES=1: one handshake -> WRITE next cycle at address 0 -> done one cycle later.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and default sizing for the CNN weight-load path.
package cnn_pkg;

    typedef logic signed [1:0] weight_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } wl_state_t;

    localparam int DEF_KERNEL_SIZE  = 3;
    localparam int DEF_NUM_FEATURES = 10;

endpackage

// File: rtl/weight_load_ctrl.sv
// Assembles a serial stream of 2-bit weights into one kernel per feature and
// issues one active-low memory write per kernel at consecutive addresses.
module weight_load_ctrl
    import cnn_pkg::*;
#(
    parameter int KERNEL_SIZE  = DEF_KERNEL_SIZE,
    parameter int NUM_FEATURES = DEF_NUM_FEATURES,
    localparam int K2 = KERNEL_SIZE * KERNEL_SIZE,
    localparam int AW = $clog2(NUM_FEATURES) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          w_valid,
    input  weight_t       w_data,
    output logic          w_ready,
    output logic [AW-1:0] address_w,
    output logic          feature_WrEn,
    output weight_t       weights_input [K2],
    output logic          busy,
    output logic          done,
    output logic          loaded
);

    localparam int EW = (K2 > 1) ? $clog2(K2) : 1;
    localparam logic [EW-1:0] ELEM_LAST = EW'(K2 - 1);
    localparam logic [AW-1:0] FEAT_LAST = AW'(NUM_FEATURES - 1);

    wl_state_t     state_q, state_d;
    logic [EW-1:0] elem_q, elem_d;
    logic [AW-1:0] feat_q, feat_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          loaded_q, loaded_d;
    weight_t       buf_q  [K2];
    weight_t       buf_d  [K2];
    weight_t       wout_q [K2];
    weight_t       wout_d [K2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            elem_q   <= '0;
            feat_q   <= '0;
            addr_q   <= '0;
            loaded_q <= 1'b0;
            buf_q    <= '{default: '0};
            wout_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            elem_q   <= elem_d;
            feat_q   <= feat_d;
            addr_q   <= addr_d;
            loaded_q <= loaded_d;
            buf_q    <= buf_d;
            wout_q   <= wout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        elem_d   = elem_q;
        feat_d   = feat_q;
        addr_d   = addr_q;
        loaded_d = loaded_q;
        buf_d    = buf_q;
        wout_d   = wout_q;
        if (abort) begin
            state_d  = IDLE;
            elem_d   = '0;
            feat_d   = '0;
            loaded_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d  = COLLECT;
                        elem_d   = '0;
                        feat_d   = '0;
                        loaded_d = 1'b0;
                    end
                end
                COLLECT: begin
                    if (w_valid) begin
                        for (int i = 0; i < K2; i++) begin
                            if (elem_q == EW'(i)) buf_d[i] = w_data;
                        end
                        if (elem_q == ELEM_LAST) begin
                            // Output registers load here so they are already
                            // stable for the whole WRITE cycle.
                            elem_d  = '0;
                            state_d = WRITE;
                            addr_d  = feat_q;
                            wout_d  = buf_d;
                        end else begin
                            elem_d = elem_q + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (feat_q == FEAT_LAST) begin
                        state_d = DONE;
                    end else begin
                        feat_d  = feat_q + 1'b1;
                        state_d = COLLECT;
                    end
                end
                DONE: begin
                    loaded_d = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Strobes decode from the state register alone so they stay glitch-free
    // across the memory's negedge write.
    assign w_ready       = (state_q == COLLECT);
    assign feature_WrEn  = (state_q != WRITE);
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign loaded        = loaded_q;
    assign address_w     = addr_q;
    assign weights_input = wout_q;

endmodule
